// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants and encodings for the SRAM-backed memory stage
package mem_stage_pkg;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_DEST_W      = 4;
   localparam int DEF_SRAM_ADDR_W = 17;
   localparam int DEF_WAIT_STATES = 5;
   localparam int DEF_BASE_ADDR   = 1024;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t ACCESS = 2'd1;
   localparam state_t DONE   = 2'd2;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Wait counter only ever holds WAIT_STATES-1, so clog2 bits suffice (min 1).
   function automatic int cnt_width(input int ws);
      return (ws > 1) ? $clog2(ws) : 1;
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - SRAM access FSM: wait counter, strobes, read-data register, req/ready handshake
module sram_ctrl
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
   parameter int WAIT_STATES = DEF_WAIT_STATES
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic                   op_wr,
   input  logic [SRAM_ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0]      wdata,
   input  logic [DATA_W-1:0]      rdata,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0]      sram_wdata,
   output logic                   sram_we_n,
   output logic                   sram_oe_n,
   output logic [DATA_W-1:0]      data_out
);

   localparam int              CNT_W    = cnt_width(WAIT_STATES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

   state_t           state;
   logic             op_q;
   logic [CNT_W-1:0] cnt;

   // sram_addr/sram_wdata are the capture registers themselves, so they hold between accesses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         op_q       <= OP_RD;
         cnt        <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         data_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  op_q       <= op_wr ? OP_WR : OP_RD;
                  sram_addr  <= addr;
                  sram_wdata <= wdata;
                  cnt        <= CNT_LOAD;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (op_q == OP_RD)
                     data_out <= rdata;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign sram_we_n = !((state == ACCESS) && (op_q == OP_WR));
   assign sram_oe_n = !((state == ACCESS) && (op_q == OP_RD));
   assign ready     = (state == IDLE) ? !req : (state == DONE);

endmodule

// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - pipeline MEM stage with wait-stated SRAM port; MEM_PERF_CNT_EN adds perf counters
module mem_stage_sram
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DEST_W      = DEF_DEST_W,
   parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
   parameter int WAIT_STATES = DEF_WAIT_STATES,
   parameter int BASE_ADDR   = DEF_BASE_ADDR
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            pc_in,
   input  logic                   wb_en_in,
   input  logic                   mem_r_en_in,
   input  logic                   mem_w_en_in,
   input  logic [ADDR_W-1:0]      alu_result_in,
   input  logic [DATA_W-1:0]      val_rm,
   input  logic [DEST_W-1:0]      dest_in,
   output logic [31:0]            pc,
   output logic                   wb_en,
   output logic                   mem_r_en,
   output logic [ADDR_W-1:0]      alu_result,
   output logic [DEST_W-1:0]      dest,
   output logic [DATA_W-1:0]      data_mem_out,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0]      sram_wdata,
   input  logic [DATA_W-1:0]      sram_rdata,
   output logic                   sram_we_n,
   output logic                   sram_oe_n
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0]            stall_cycles,
   output logic [31:0]            access_count
`endif
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   logic                   req;
   logic [SRAM_ADDR_W-1:0] word_addr;

   assign pc         = pc_in;
   assign wb_en      = wb_en_in;
   assign mem_r_en   = mem_r_en_in;
   assign alu_result = alu_result_in;
   assign dest       = dest_in;

   assign req = mem_r_en_in | mem_w_en_in;
   // Addresses below BASE_ADDR wrap silently; byte offset bits are dropped.
   assign word_addr = SRAM_ADDR_W'((alu_result_in - BASE) >> 2);

   sram_ctrl #(
      .DATA_W      (DATA_W),
      .SRAM_ADDR_W (SRAM_ADDR_W),
      .WAIT_STATES (WAIT_STATES)
   ) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .op_wr      (mem_w_en_in),
      .addr       (word_addr),
      .wdata      (val_rm),
      .rdata      (sram_rdata),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_we_n  (sram_we_n),
      .sram_oe_n  (sram_oe_n),
      .data_out   (data_mem_out)
   );

`ifdef MEM_PERF_CNT_EN
   // A stall that starts after a ready cycle is always the IDLE cycle that launches an access.
   logic prev_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
         access_count <= '0;
         prev_ready   <= 1'b1;
      end else begin
         prev_ready <= ready;
         if (!ready)
            stall_cycles <= stall_cycles + 32'd1;
         if (!ready && prev_ready)
            access_count <= access_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb/tb_mem_stage_sram.sv - randomized self-checking bench for mem_stage_sram
module tb_mem_stage_sram;

`ifdef MEM_PERF_CNT_EN
   localparam int WS = 2;
`else
   localparam int WS = 5;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in, alu_result_in, val_rm, sram_rdata;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [3:0]  dest_in;
   logic [31:0] pc, alu_result, data_mem_out, sram_wdata;
   logic        wb_en, mem_r_en, ready, sram_we_n, sram_oe_n;
   logic [3:0]  dest;
   logic [16:0] sram_addr;
`ifdef MEM_PERF_CNT_EN
   logic [31:0] stall_cycles, access_count;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_dmem = 32'h0;

   always #5 clk = ~clk;

   mem_stage_sram #(.WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en_in(wb_en_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .alu_result_in(alu_result_in), .val_rm(val_rm), .dest_in(dest_in),
      .pc(pc), .wb_en(wb_en), .mem_r_en(mem_r_en), .alu_result(alu_result),
      .dest(dest), .data_mem_out(data_mem_out), .ready(ready),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
`ifdef MEM_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .access_count(access_count)
`endif
   );

   // SRAM word index = (byte address - 1024) / 4, modulo 2^17
   function automatic logic [16:0] exp_word(input logic [31:0] a);
      logic [31:0] off;
      off = (a - 32'd1024) / 4;
      return off[16:0];
   endfunction

   // Drives one request held until the stage reports ready, then retires it.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdat,
                            output int n_we, output int n_oe, output int n_stall,
                            output int n_total, output int n_overlap,
                            output logic [16:0] addr_seen, output logic [31:0] wdata_seen,
                            output logic [31:0] dmem_done);
      logic done;
      n_we = 0; n_oe = 0; n_stall = 0; n_total = 0; n_overlap = 0;
      addr_seen = '0; wdata_seen = '0; dmem_done = '0; done = 1'b0;
      pc_in = $urandom; wb_en_in = 1'($urandom); dest_in = 4'($urandom);
      mem_r_en_in = rd; mem_w_en_in = wr; alu_result_in = a; val_rm = wd; sram_rdata = rdat;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         n_total++;
         if (!sram_we_n) n_we++;
         if (!sram_oe_n) n_oe++;
         if (!sram_we_n && !sram_oe_n) n_overlap++;
         if (!sram_we_n || !sram_oe_n) begin
            addr_seen  = sram_addr;
            wdata_seen = sram_wdata;
         end
         if (!ready) n_stall++;
         else begin
            done      = 1'b1;
            dmem_done = data_mem_out;
         end
      end
      @(posedge clk); #1;
      mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; pc_in = '0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
      alu_result_in = '0; val_rm = '0; dest_in = '0; sram_rdata = '0;
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
      checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b expected 1", sram_oe_n); end
      checks++; if (data_mem_out !== 32'h0) begin errors++; $display("FAIL reset_dmem: got %h expected 0", data_mem_out); end
      checks++; if (sram_addr !== 17'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
      checks++; if (sram_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", sram_wdata); end
   endtask

   // Pass-through and the IDLE ready value are combinational, so they must track inputs even in reset.
   task automatic test_passthrough();
      for (int i = 0; i < 8; i++) begin
         pc_in = $urandom; wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom);
         mem_w_en_in = 1'($urandom); alu_result_in = $urandom; dest_in = 4'($urandom);
         #2;
         checks++; if (pc !== pc_in) begin errors++; $display("FAIL pt_pc: got %h expected %h", pc, pc_in); end
         checks++; if (wb_en !== wb_en_in) begin errors++; $display("FAIL pt_wb_en: got %b expected %b", wb_en, wb_en_in); end
         checks++; if (mem_r_en !== mem_r_en_in) begin errors++; $display("FAIL pt_mem_r_en: got %b expected %b", mem_r_en, mem_r_en_in); end
         checks++; if (alu_result !== alu_result_in) begin errors++; $display("FAIL pt_alu: got %h expected %h", alu_result, alu_result_in); end
         checks++; if (dest !== dest_in) begin errors++; $display("FAIL pt_dest: got %h expected %h", dest, dest_in); end
         checks++; if (ready !== !(mem_r_en_in | mem_w_en_in)) begin errors++; $display("FAIL pt_ready: got %b expected %b", ready, !(mem_r_en_in | mem_w_en_in)); end
      end
      mem_r_en_in = 0; mem_w_en_in = 0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_load();
      int we, oe, st, tot, ov; logic [16:0] ad; logic [31:0] wdv, dm;
      do_access(1, 0, 32'd1032, $urandom, 32'hDEADBEEF, we, oe, st, tot, ov, ad, wdv, dm);
      model_dmem = 32'hDEADBEEF;
      checks++; if (oe !== WS) begin errors++; $display("FAIL load_oe_cycles: got %0d expected %0d", oe, WS); end
      checks++; if (we !== 0) begin errors++; $display("FAIL load_we_cycles: got %0d expected 0", we); end
      checks++; if (st !== WS + 1) begin errors++; $display("FAIL load_stall: got %0d expected %0d", st, WS + 1); end
      checks++; if (tot !== WS + 2) begin errors++; $display("FAIL load_total: got %0d expected %0d", tot, WS + 2); end
      checks++; if (ad !== 17'd2) begin errors++; $display("FAIL load_addr: got %0d expected 2", ad); end
      checks++; if (dm !== model_dmem) begin errors++; $display("FAIL load_data: got %h expected %h", dm, model_dmem); end
   endtask

   task automatic test_store();
      int we, oe, st, tot, ov; logic [16:0] ad; logic [31:0] wdv, dm;
      do_access(0, 1, 32'd1024, 32'h12345678, $urandom, we, oe, st, tot, ov, ad, wdv, dm);
      checks++; if (we !== WS) begin errors++; $display("FAIL store_we_cycles: got %0d expected %0d", we, WS); end
      checks++; if (oe !== 0) begin errors++; $display("FAIL store_oe_cycles: got %0d expected 0", oe); end
      checks++; if (ad !== 17'd0) begin errors++; $display("FAIL store_addr: got %0d expected 0", ad); end
      checks++; if (wdv !== 32'h12345678) begin errors++; $display("FAIL store_wdata: got %h expected 12345678", wdv); end
      checks++; if (data_mem_out !== model_dmem) begin errors++; $display("FAIL store_dmem_kept: got %h expected %h", data_mem_out, model_dmem); end
   endtask

   task automatic test_both();
      int we, oe, st, tot, ov; logic [16:0] ad; logic [31:0] wdv, dm, wd;
      wd = $urandom;
      do_access(1, 1, 32'd1040, wd, $urandom, we, oe, st, tot, ov, ad, wdv, dm);
      checks++; if (we !== WS) begin errors++; $display("FAIL both_we_cycles: got %0d expected %0d", we, WS); end
      checks++; if (oe !== 0) begin errors++; $display("FAIL both_oe_cycles: got %0d expected 0", oe); end
      checks++; if (wdv !== wd) begin errors++; $display("FAIL both_wdata: got %h expected %h", wdv, wd); end
      checks++; if (dm !== model_dmem) begin errors++; $display("FAIL both_dmem_kept: got %h expected %h", dm, model_dmem); end
   endtask

   task automatic test_back_to_back();
      int we, oe, st, tot, ov; logic [16:0] ad; logic [31:0] wdv, dm, rd;
      rd = $urandom;
      do_access(1, 0, 32'd2048, $urandom, rd, we, oe, st, tot, ov, ad, wdv, dm);
      model_dmem = rd;
      checks++; if (tot !== WS + 2) begin errors++; $display("FAIL b2b_load_total: got %0d expected %0d", tot, WS + 2); end
      checks++; if (oe !== WS || ov !== 0) begin errors++; $display("FAIL b2b_load_strobes: got oe=%0d ov=%0d expected oe=%0d ov=0", oe, ov, WS); end
      checks++; if (dm !== model_dmem) begin errors++; $display("FAIL b2b_load_data: got %h expected %h", dm, model_dmem); end
      do_access(0, 1, 32'd2052, $urandom, $urandom, we, oe, st, tot, ov, ad, wdv, dm);
      checks++; if (tot !== WS + 2) begin errors++; $display("FAIL b2b_store_total: got %0d expected %0d", tot, WS + 2); end
      checks++; if (we !== WS || oe !== 0 || ov !== 0) begin errors++; $display("FAIL b2b_store_strobes: got we=%0d oe=%0d ov=%0d expected we=%0d", we, oe, ov, WS); end
      checks++; if (ad !== exp_word(32'd2052)) begin errors++; $display("FAIL b2b_store_addr: got %0d expected %0d", ad, exp_word(32'd2052)); end
      @(negedge clk);
      checks++; if (sram_we_n !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_after: got we_n=%b ready=%b expected 1/1", sram_we_n, ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int we, oe, st, tot, ov, kind, gap; logic [16:0] ad; logic [31:0] wdv, dm, a, wd, rdat;
      logic is_rd;
      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 2);
         a    = (i % 4 == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
         wd   = $urandom; rdat = $urandom;
         is_rd = (kind == 0);
         do_access(kind != 1, kind != 0, a, wd, rdat, we, oe, st, tot, ov, ad, wdv, dm);
         if (is_rd) model_dmem = rdat;
         checks++; if (oe !== (is_rd ? WS : 0) || we !== (is_rd ? 0 : WS) || ov !== 0) begin
            errors++; $display("FAIL rand_strobes[%0d]: got we=%0d oe=%0d ov=%0d kind=%0d", i, we, oe, ov, kind); end
         checks++; if (st !== WS + 1 || tot !== WS + 2) begin
            errors++; $display("FAIL rand_timing[%0d]: got stall=%0d total=%0d expected %0d/%0d", i, st, tot, WS + 1, WS + 2); end
         checks++; if (ad !== exp_word(a)) begin errors++; $display("FAIL rand_addr[%0d]: got %h expected %h", i, ad, exp_word(a)); end
         if (!is_rd) begin
            checks++; if (wdv !== wd) begin errors++; $display("FAIL rand_wdata[%0d]: got %h expected %h", i, wdv, wd); end
         end
         checks++; if (dm !== model_dmem) begin errors++; $display("FAIL rand_dmem[%0d]: got %h expected %h", i, dm, model_dmem); end
         gap = $urandom_range(0, 2);
         repeat (gap) #10;
      end
   endtask

   task automatic test_reset_mid_access();
      int we, oe, st, tot, ov, bad; logic [16:0] ad; logic [31:0] wdv, dm, rd;
      mem_r_en_in = 0; mem_w_en_in = 1; alu_result_in = 32'd1040; val_rm = $urandom;
      repeat (4) @(negedge clk);
      checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rstmid_in_write: got we_n=%b expected 0", sram_we_n); end
      rst = 1'b0; mem_w_en_in = 0;
      #1;
      model_dmem = 32'h0;
      checks++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin errors++; $display("FAIL rstmid_strobes: got we_n=%b oe_n=%b expected 1/1", sram_we_n, sram_oe_n); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
      checks++; if (data_mem_out !== model_dmem) begin errors++; $display("FAIL rstmid_dmem: got %h expected 0", data_mem_out); end
      checks++; if (sram_addr !== 17'h0 || sram_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_regs: got addr=%h wdata=%h expected 0/0", sram_addr, sram_wdata); end
      @(posedge clk); #1;
      rst = 1'b1;
      bad = 0;
      repeat (WS + 4) begin
         @(negedge clk);
         if (sram_we_n !== 1'b1 || ready !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_aborted: got %0d active cycles expected 0", bad); end
      @(posedge clk); #1;
      rd = $urandom;
      do_access(1, 0, 32'd1028, $urandom, rd, we, oe, st, tot, ov, ad, wdv, dm);
      model_dmem = rd;
      checks++; if (tot !== WS + 2 || oe !== WS) begin errors++; $display("FAIL rstmid_next_load: got total=%0d oe=%0d expected %0d/%0d", tot, oe, WS + 2, WS); end
      checks++; if (dm !== model_dmem) begin errors++; $display("FAIL rstmid_next_data: got %h expected %h", dm, model_dmem); end
   endtask

`ifdef MEM_PERF_CNT_EN
   task automatic test_perf();
      int we, oe, st, tot, ov; logic [16:0] ad; logic [31:0] wdv, dm, rd;
      rst = 1'b0; #3; rst = 1'b1; #7;
      checks++; if (access_count !== 32'd0 || stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_reset: got acc=%0d stall=%0d expected 0/0", access_count, stall_cycles); end
      rd = $urandom;
      do_access(1, 0, 32'd1100, $urandom, rd, we, oe, st, tot, ov, ad, wdv, dm);
      model_dmem = rd;
      do_access(0, 1, 32'd1200, $urandom, $urandom, we, oe, st, tot, ov, ad, wdv, dm);
      #20;
      do_access(1, 1, 32'd1300, $urandom, $urandom, we, oe, st, tot, ov, ad, wdv, dm);
      @(negedge clk);
      checks++; if (access_count !== 32'd3) begin errors++; $display("FAIL perf_access_count: got %0d expected 3", access_count); end
      checks++; if (stall_cycles !== 32'(3 * (WS + 1))) begin errors++; $display("FAIL perf_stall_cycles: got %0d expected %0d", stall_cycles, 3 * (WS + 1)); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_passthrough();
      test_load();
      test_store();
      test_both();
      test_back_to_back();
      test_random();
      test_reset_mid_access();
`ifdef MEM_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Parametrised memory stage for the ARM-style 5-stage pipeline. Sits between the EXE and MEM/WB pipeline registers.
- Passes through control, PC and destination fields unchanged.
- Replaces the single-cycle data memory with an external SRAM port that has a configurable number of wait states.
- Generates `ready` so the hazard/freeze logic can hold the upstream pipeline during multi-cycle accesses.

Parameters:
- DATA_W, 32, data/ALU word width
- ADDR_W, 32, ALU address width
- DEST_W, 4, register-file destination index width
- SRAM_ADDR_W, 17, external SRAM word-address width
- WAIT_STATES, 5, SRAM access cycles per transfer (>=1)
- BASE_ADDR, 1024, byte address mapped to SRAM word 0

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_in  in  32  PC from EXE register
- wb_en_in  in  1  writeback enable
- mem_r_en_in  in  1  load request
- mem_w_en_in  in  1  store request
- alu_result_in  in  ADDR_W  effective byte address / ALU result
- val_rm  in  DATA_W  store data
- dest_in  in  DEST_W  destination register
- pc  out  32  = pc_in
- wb_en  out  1  = wb_en_in
- mem_r_en  out  1  = mem_r_en_in
- alu_result  out  ADDR_W  = alu_result_in
- dest  out  DEST_W  = dest_in
- data_mem_out  out  DATA_W  registered load data
- ready  out  1  1 = stage may advance; 0 = freeze PC, IF/ID/EXE registers
- sram_addr  out  SRAM_ADDR_W  word address
- sram_wdata  out  DATA_W  write data
- sram_rdata  in  DATA_W  read data
- sram_we_n  out  1  active-low write strobe
- sram_oe_n  out  1  active-low output enable

Behaviour:
- Pass-through outputs are purely combinational from their inputs; they are not affected by reset.
- Address mapping: `sram_addr = ((alu_result_in - BASE_ADDR) >> 2)`, truncated to SRAM_ADDR_W. Addresses below BASE_ADDR wrap modulo 2^SRAM_ADDR_W and are not flagged. Low 2 bits are ignored.
- `req = mem_r_en_in | mem_w_en_in`. If both are set, the write wins and the read is ignored.
- FSM states:
  - IDLE: `ready = ~req`. If `req`, capture op type, address and val_rm into internal registers; go to ACCESS and load a counter with WAIT_STATES-1.
  - ACCESS: `sram_addr`/`sram_wdata` are driven from the captured registers.
    - Write: `sram_we_n = 0`.
    - Read: `sram_oe_n = 0`.
    - The counter decrements each cycle.
    - On the cycle the counter reaches 0, a read samples `sram_rdata` into `data_mem_out`; the FSM then goes to DONE.
    - `ready = 0`.
  - DONE: `ready = 1`, strobes inactive. Go to IDLE unconditionally. The pipeline register captures results at this edge.
- Latency: a request first seen in IDLE at cycle 0 gives ACCESS for cycles 1..WAIT_STATES, DONE at cycle WAIT_STATES+1, and the stall lasts WAIT_STATES+1 cycles.
- Back-to-back: after DONE, the next instruction's request is evaluated in IDLE on the following cycle, so each access costs WAIT_STATES+2 cycles.
- `data_mem_out` holds its value between loads; stores do not change it.
- Reset (`rst = 0`, at any time including mid-ACCESS):
  - FSM goes to IDLE; counter = 0.
  - `sram_we_n = 1`, `sram_oe_n = 1`.
  - `data_mem_out = 0`, `sram_addr = 0`, `sram_wdata = 0`.
  - `ready` = combinational IDLE value.
  - An aborted write does not complete.
- In IDLE with no request, `sram_we_n` and `sram_oe_n` are 1 and `sram_addr`/`sram_wdata` hold their last captured values.

Optional Feature:
- Macro MEM_PERF_CNT_EN.
- Defined: adds outputs `stall_cycles[31:0]` (increments every cycle `ready = 0`) and `access_count[31:0]` (increments on each IDLE→ACCESS transition). Both reset to 0 asynchronously and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package `mem_stage_pkg`: state enum (IDLE, ACCESS, DONE), default width constants, BASE_ADDR default, op-type encoding (OP_RD, OP_WR).
- One sub-module, `sram_ctrl`: FSM, wait counter, SRAM strobes and read-data register, with a `req`/`ready` handshake.
- `mem_stage_sram` itself holds the pass-through wiring, address mapping and optional counters.

Test Plan:
- Load: WAIT_STATES=5, alu_result_in=1032, mem_r_en_in=1, sram_rdata=0xDEADBEEF → sram_addr=2, sram_oe_n=0 for 5 cycles, ready=0 for 6 cycles, data_mem_out=0xDEADBEEF at DONE.
- Store: alu_result_in=1024, val_rm=0x12345678, mem_w_en_in=1 → sram_addr=0, sram_wdata=0x12345678, sram_we_n=0 for exactly 5 cycles, data_mem_out unchanged.
- Both mem_r_en_in and mem_w_en_in = 1 → write performed, sram_oe_n stays 1.
- Back-to-back load then store (upstream frozen per ready) → two complete 7-cycle transactions, no overlapping strobes.
- rst pulled low during the 3rd ACCESS cycle of a write → sram_we_n=1 immediately, FSM in IDLE, data_mem_out=0, ready=1 with no request.
- MEM_PERF_CNT_EN defined, three accesses with WAIT_STATES=2 → access_count=3, stall_cycles=9.
